// File: rtl/systolic_pkg.sv
// Shared definitions for the systolic processing element: default widths,
// the PE state type and a generic signed saturation helper used when the
// SYSTOLIC_PE_SATURATE_EN build option is enabled.
package systolic_pkg;

  localparam int DEFAULT_WIDTH     = 32;
  localparam int DEFAULT_ACC_WIDTH = 32;
  localparam int DEFAULT_K_DEPTH   = 4;

  typedef enum logic {
    IDLE  = 1'b0,
    ACCUM = 1'b1
  } pe_state_t;

  // Clamp a 128-bit signed value into the signed range of a w-bit word
  // (w <= 127); the caller truncates the result to w bits.
  function automatic logic signed [127:0] sat_signed(input logic signed [127:0] v,
                                                     input int unsigned         w);
    logic signed [127:0] max_v;
    logic signed [127:0] min_v;
    max_v = (128'sd1 <<< (w - 1)) - 128'sd1;
    min_v = ~max_v;
    if (v > max_v) begin
      return max_v;
    end else if (v < min_v) begin
      return min_v;
    end
    return v;
  endfunction

endpackage

// File: rtl/pe_mac_unit.sv
// Combinational multiply-accumulate step for systolic_pe.
// Forms the full-width signed product of the two operands and adds it to the
// incoming accumulator. With SYSTOLIC_PE_SATURATE_EN defined, the product and
// the sum are both clamped to the signed ACC_WIDTH range; otherwise the sum
// wraps modulo 2^ACC_WIDTH.
module pe_mac_unit
  import systolic_pkg::*;
#(
  parameter int WIDTH     = DEFAULT_WIDTH,
  parameter int ACC_WIDTH = DEFAULT_ACC_WIDTH
) (
  input  logic [WIDTH-1:0]     a_i,
  input  logic [WIDTH-1:0]     b_i,
  input  logic [ACC_WIDTH-1:0] acc_i,
  output logic [ACC_WIDTH-1:0] next_acc_o
);

  localparam int PW = 2 * WIDTH;
  // One guard bit above the wider of product and accumulator.
  localparam int XW = ((PW > ACC_WIDTH) ? PW : ACC_WIDTH) + 1;

  logic signed [PW-1:0] prod;
  logic signed [XW-1:0] prod_x;

  assign prod   = $signed(a_i) * $signed(b_i);
  assign prod_x = {{(XW - PW){prod[PW-1]}}, prod};

`ifdef SYSTOLIC_PE_SATURATE_EN
  logic signed [127:0]       prod_sat_w;
  logic signed [ACC_WIDTH-1:0] prod_sat;
  logic signed [ACC_WIDTH:0]   sum_ext;
  logic signed [127:0]       sum_sat_w;

  // Clamp the product first so an oversized product cannot wrap, then add
  // with one guard bit and clamp the sum back onto the rails.
  always_comb begin
    prod_sat_w = sat_signed({{(128 - XW){prod_x[XW-1]}}, prod_x}, ACC_WIDTH);
    prod_sat   = ACC_WIDTH'(prod_sat_w);
    sum_ext    = {acc_i[ACC_WIDTH-1], acc_i} + {prod_sat[ACC_WIDTH-1], prod_sat};
    sum_sat_w  = sat_signed({{(127 - ACC_WIDTH){sum_ext[ACC_WIDTH]}}, sum_ext}, ACC_WIDTH);
    next_acc_o = ACC_WIDTH'(sum_sat_w);
  end
`else
  logic signed [XW-1:0] acc_x;

  // Wrap-around accumulation: only the low ACC_WIDTH bits of the sum survive.
  always_comb begin
    acc_x      = {{(XW - ACC_WIDTH){acc_i[ACC_WIDTH-1]}}, acc_i};
    next_acc_o = ACC_WIDTH'(acc_x + prod_x);
  end
`endif

endmodule

// File: rtl/systolic_pe.sv
// Systolic matrix-multiply processing element.
// Forwards the A and B operand streams one register stage downstream and
// accumulates K_DEPTH paired products into one result word with a one-cycle
// valid pulse. Build option: SYSTOLIC_PE_SATURATE_EN selects saturating
// accumulation (see pe_mac_unit); the default build wraps.
module systolic_pe
  import systolic_pkg::*;
#(
  parameter int WIDTH     = DEFAULT_WIDTH,
  parameter int ACC_WIDTH = DEFAULT_ACC_WIDTH,
  parameter int K_DEPTH   = DEFAULT_K_DEPTH
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 a_in_valid,
  input  logic [WIDTH-1:0]     a_in,
  input  logic                 b_in_valid,
  input  logic [WIDTH-1:0]     b_in,
  output logic                 a_out_valid,
  output logic [WIDTH-1:0]     a_out,
  output logic                 b_out_valid,
  output logic [WIDTH-1:0]     b_out,
  output logic [ACC_WIDTH-1:0] result,
  output logic                 result_valid,
  output logic                 pair_error
);

  // Counter is 8 bits wide because K_DEPTH never exceeds 255.
  localparam logic [7:0] K_LAST = 8'(K_DEPTH);

  pe_state_t            state_q, state_d;
  logic [7:0]           cnt_q, cnt_d;
  logic [ACC_WIDTH-1:0] acc_q, acc_d;
  logic [ACC_WIDTH-1:0] result_q, result_d;
  logic                 result_valid_q, result_valid_d;
  logic                 pair_error_q, pair_error_d;

  logic                 a_out_valid_q, b_out_valid_q;
  logic [WIDTH-1:0]     a_out_q, b_out_q;

  logic                 accept;
  logic [ACC_WIDTH-1:0] acc_base;
  logic [ACC_WIDTH-1:0] next_acc;

  assign accept   = a_in_valid & b_in_valid;
  // A fresh sum always starts from zero, independent of the stored accumulator.
  assign acc_base = (state_q == IDLE) ? '0 : acc_q;

  pe_mac_unit #(
    .WIDTH    (WIDTH),
    .ACC_WIDTH(ACC_WIDTH)
  ) u_mac (
    .a_i       (a_in),
    .b_i       (b_in),
    .acc_i     (acc_base),
    .next_acc_o(next_acc)
  );

  // Next-state logic: accept paired products, complete on the K_DEPTH-th one.
  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    acc_d          = acc_q;
    result_d       = result_q;
    result_valid_d = 1'b0;
    pair_error_d   = pair_error_q | (a_in_valid ^ b_in_valid);
    if (accept) begin
      if (cnt_q + 8'd1 == K_LAST) begin
        result_d       = next_acc;
        result_valid_d = 1'b1;
        acc_d          = '0;
        cnt_d          = 8'd0;
        state_d        = IDLE;
      end else begin
        acc_d   = next_acc;
        cnt_d   = cnt_q + 8'd1;
        state_d = ACCUM;
      end
    end
  end

  // Accumulator state machine with registered result outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= IDLE;
      cnt_q          <= 8'd0;
      acc_q          <= '0;
      result_q       <= '0;
      result_valid_q <= 1'b0;
      pair_error_q   <= 1'b0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      acc_q          <= acc_d;
      result_q       <= result_d;
      result_valid_q <= result_valid_d;
      pair_error_q   <= pair_error_d;
    end
  end

  // Operand forwarding: unconditional one-cycle delay of data and valid.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_out_valid_q <= 1'b0;
      a_out_q       <= '0;
      b_out_valid_q <= 1'b0;
      b_out_q       <= '0;
    end else begin
      a_out_valid_q <= a_in_valid;
      a_out_q       <= a_in;
      b_out_valid_q <= b_in_valid;
      b_out_q       <= b_in;
    end
  end

  assign a_out_valid  = a_out_valid_q;
  assign a_out        = a_out_q;
  assign b_out_valid  = b_out_valid_q;
  assign b_out        = b_out_q;
  assign result       = result_q;
  assign result_valid = result_valid_q;
  assign pair_error   = pair_error_q;

endmodule

// File: doc/systolic_pe.md
Name: systolic_pe

Overview:
- Processing element for the systolic matrix-multiply array.
- Sits directly downstream of the 2-deep valid/data delay lines.
  - Consumes an A-operand stream (row skew) and a B-operand stream (column skew).
  - Forms a K_DEPTH-term dot product.
  - Forwards both operand streams to the next PE right/down with one register stage.
- Emits one result word plus a valid pulse per completed dot product.

Parameters:
- WIDTH, 32, operand width; signed two's complement.
- ACC_WIDTH, 32, accumulator/result width.
- K_DEPTH, 4, products per dot product; legal range 1..255.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  reset, synchronous, active-high.
- a_in_valid  in  1  A operand valid.
- a_in  in  WIDTH  A operand.
- b_in_valid  in  1  B operand valid.
- b_in  in  WIDTH  B operand.
- a_out_valid  out  1  a_in_valid delayed one cycle.
- a_out  out  WIDTH  a_in delayed one cycle.
- b_out_valid  out  1  b_in_valid delayed one cycle.
- b_out  out  WIDTH  b_in delayed one cycle.
- result  out  ACC_WIDTH  completed dot product; held until next completion.
- result_valid  out  1  one-cycle pulse per completed dot product.
- pair_error  out  1  sticky; set when exactly one of a_in_valid/b_in_valid is high.

Behaviour:
- Reset: one clock and one reset only; reset is synchronous and active-high.
  - While rst is high at a rising edge, all of the following are 0: every output, the accumulator, the product counter and the state.
  - Reset mid-accumulation discards the partial sum; no result_valid is produced for it.
- Forwarding:
  - a_out/a_out_valid and b_out/b_out_valid are plain one-cycle registers of their inputs.
  - They update every cycle regardless of pairing, state or pair_error.
  - Data is forwarded even when valid is low.
- Product acceptance:
  - A product is accepted in a cycle only when a_in_valid and b_in_valid are both high.
  - p = a_in*b_in, computed full-width 2*WIDTH signed, then sign-truncated/extended to ACC_WIDTH.
- State machine (state, cnt):
  - IDLE: acc=0, cnt=0. Accepted product: acc<=p, cnt<=1, go to ACCUM. If K_DEPTH==1, complete immediately (see completion).
  - ACCUM: accepted product: acc<=acc+p, cnt<=cnt+1. Non-accepted cycles hold acc and cnt (bubbles allowed).
  - Completion: the accepted product that makes cnt reach K_DEPTH loads result<=acc+p and pulses result_valid high next cycle.
    - acc and cnt clear to 0; state goes to IDLE.
    - Latency: final product edge to result_valid is 1 cycle.
  - Back-to-back: a product accepted in the cycle immediately after completion starts a new sum (acc<=p). No dead cycle.
- Arithmetic: without the optional feature, accumulation wraps modulo 2^ACC_WIDTH.
- result holds its value between completions; result_valid is low otherwise.
- pair_error:
  - Set on any cycle with a_in_valid XOR b_in_valid.
  - Cleared only by rst.
  - Does not alter accumulation; the unpaired operand is simply not accepted.

Optional Feature:
- Macro: SYSTOLIC_PE_SATURATE_EN.
- Defined: every addition (including the final one) clamps to the signed ACC_WIDTH range.
  - Overflow gives 2^(ACC_WIDTH-1)-1; underflow gives -2^(ACC_WIDTH-1).
  - Once clamped, later opposite-sign products move away from the rail normally.
  - Products wider than ACC_WIDTH are clamped before adding.
- Undefined: wrap-around arithmetic as in Behaviour; no clamp logic is synthesised.

Decomposition:
- Package systolic_pkg:
  - Default WIDTH/ACC_WIDTH constants.
  - pe_state_t enum {IDLE, ACCUM}.
  - Function for signed saturation to ACC_WIDTH.
- One sub-module, pe_mac_unit: combinational multiply + add + optional saturate, returning next_acc.
- Counter, state machine, forwarding registers and pair_error stay in systolic_pe.

Test Plan:
- Reset/forwarding: hold rst 3 cycles with inputs toggling -> all outputs 0. Release; a_in=5,v=1 at t -> a_out=5, a_out_valid=1 at t+1.
- Basic dot product, K_DEPTH=4: pairs (1,2),(3,4),(5,6),(7,8) on consecutive cycles -> result=100 with one-cycle result_valid, one cycle after the 4th pair.
- Bubbles and back-to-back:
  - Same four pairs with 2 idle cycles between pairs 2 and 3 -> result=100.
  - Immediately follow with (1,1)x4 -> second result=4, result_valid pulses exactly twice.
- Reset mid-operation: 2 pairs, then rst for 1 cycle, then (2,2)x4 -> single result=16; no pulse for the aborted sum.
- Pair error: a_in_valid=1, b_in_valid=0 for one cycle amid a sum of (1,1)x4 -> pair_error=1 and stays 1; result=4.
- Overflow, ACC_WIDTH=32: pairs (0x40000000,2),(0x40000000,2),(0,0),(0,0) -> without macro result=0x00000000; with SYSTOLIC_PE_SATURATE_EN result=0x7FFFFFFF.
